cordic_seq_ctrl: RTL and testbench

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/fullAdder32b.sv | 12 +
 rtl/cordic_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the sequential CORDIC engine.
// ATAN_TBL[i] = round(atan(2^-i) * 2^30), i = 0..30, Q2.30 radians.
package cordic_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 30;
    localparam int ATAN_N = 31;

    typedef enum logic [2:0] {
        IDLE,
        XUPD,
        YUPD,
        ZUPD,
        DONE
    } state_t;

    localparam logic [DATA_W-1:0] ATAN_TBL [0:ATAN_N-1] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001
    };

    // Index 31 is never reached for legal ITER; it reads as zero.
    function automatic logic [DATA_W-1:0] atan_lut(input logic [4:0] idx);
        return (idx < 5'(ATAN_N)) ? ATAN_TBL[idx] : '0;
    endfunction

endpackage

// File: rtl/fullAdder32b.sv
// 32-bit adder/subtractor: cin=0 gives a+b, cin=1 gives a-b; combinational, result wraps mod 2^32.
// The carry-out is not needed by any user, so it is not produced.
module fullAdder32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    assign sum = a + (b ^ {32{cin}}) + {31'b0, cin};

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Rotation-mode CORDIC, one shared add/sub, three cycles per micro-rotation; done 3*ITER+1 cycles after start.
// No backpressure: start is honoured only in IDLE, ignored otherwise; gain is left uncompensated.
module cordic_seq_ctrl #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] z0,
    output logic        busy,
    output logic        done,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out
);
    import cordic_pkg::*;

    localparam logic [4:0] LAST_I = 5'(ITER - 1);

    state_t            state_q, state_d;
    logic [4:0]        i_q, i_d;
    logic              d_q, d_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic [DATA_W-1:0] xp_q, xp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W-1:0] add_sum;

    fullAdder32b u_addsub (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        d_d     = d_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xp_d    = xp_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x0;
                    y_d     = y0;
                    z_d     = z0;
                    i_d     = '0;
                    state_d = XUPD;
                end
            end
            XUPD: begin
                // d=1 (z non-negative) rotates positive: x - (y>>>i)
                d_d     = ~z_q[DATA_W-1];
                xp_d    = x_q;
                add_a   = x_q;
                add_b   = $signed(y_q) >>> i_q;
                add_cin = ~z_q[DATA_W-1];
                x_d     = add_sum;
                state_d = YUPD;
            end
            YUPD: begin
                // x_prev keeps the pre-update x so both rotations use the same vector
                add_a   = y_q;
                add_b   = $signed(xp_q) >>> i_q;
                add_cin = ~d_q;
                y_d     = add_sum;
                state_d = ZUPD;
            end
            ZUPD: begin
                add_a   = z_q;
                add_b   = atan_lut(i_q);
                add_cin = d_q;
                z_d     = add_sum;
                if (i_q == LAST_I) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 5'd1;
                    state_d = XUPD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == XUPD) || (state_d == YUPD) || (state_d == ZUPD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            d_q     <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xp_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            d_q     <= d_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xp_q    <= xp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: vector table plus random jobs against an iterative integer model,
// with hand-written sequences for start re-pulses, mid-job reset and the ITER=1 instance.
module tb_cordic_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [31:0] x0_a, y0_a, z0_a, x0_b, y0_b, z0_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] xo_a, yo_a, zo_a, xo_b, yo_b, zo_b;

    cordic_seq_ctrl #(.ITER(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .x0(x0_a), .y0(y0_a), .z0(z0_a),
        .busy(busy_a), .done(done_a),
        .x_out(xo_a), .y_out(yo_a), .z_out(zo_a)
    );

    cordic_seq_ctrl #(.ITER(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .x0(x0_b), .y0(y0_b), .z0(z0_b),
        .busy(busy_b), .done(done_b),
        .x_out(xo_b), .y_out(yo_b), .z_out(zo_b)
    );

    typedef struct {
        string       name;
        logic [31:0] x0, y0, z0;
        logic [31:0] ex, ey, ez;
    } vec_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  atan_ref [31];
    real k16;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic [31:0] act, input real exp_r);
        real diff;
        n_cmp++;
        diff = $itor($signed(act)) - exp_r;
        if (diff > 32768.0 || diff < -32768.0) begin
            n_bad++;
            $display("FAIL %s: got %08h expected about %0.1f (+/- 32768 lsb)", name, act, exp_r);
        end
    endtask

    // Textbook iteration on signed integers: d = (z >= 0), wrapping arithmetic.
    task automatic model(input logic [31:0] xi, yi, zi, input int iter,
                         output logic [31:0] xo, yo, zo);
        int x, y, z, xn, yn;
        x = xi;
        y = yi;
        z = zi;
        for (int k = 0; k < iter; k++) begin
            if (z >= 0) begin
                xn = x - (y >>> k);
                yn = y + (x >>> k);
                z  = z - atan_ref[k];
            end else begin
                xn = x + (y >>> k);
                yn = y - (x >>> k);
                z  = z + atan_ref[k];
            end
            x = xn;
            y = yn;
        end
        xo = x;
        yo = y;
        zo = z;
    endtask

    // One job on either instance; records done cycle (1 = first cycle after the sampling edge).
    task automatic run_job(input bit sel1, input logic [31:0] a, b, c, input bit repulse,
                           output int done_cyc, output int done_cnt, output int busy_err,
                           output logic [31:0] xo, yo, zo);
        int   iter;
        logic bsy, dn;
        iter = sel1 ? 1 : 16;
        @(negedge clk);
        if (sel1) begin
            x0_b = a; y0_b = b; z0_b = c; start_b = 1'b1;
        end else begin
            x0_a = a; y0_a = b; z0_a = c; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        x0_a = ~a; y0_a = ~b; z0_a = ~c;
        x0_b = ~a; y0_b = ~b; z0_b = ~c;
        done_cyc = -1;
        done_cnt = 0;
        busy_err = 0;
        xo = '0; yo = '0; zo = '0;
        for (int cyc = 1; cyc <= 3 * iter + 4; cyc++) begin
            @(negedge clk);
            bsy = sel1 ? busy_b : busy_a;
            dn  = sel1 ? done_b : done_a;
            if (bsy !== (cyc <= 3 * iter)) busy_err++;
            if (dn === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    xo = sel1 ? xo_b : xo_a;
                    yo = sel1 ? yo_b : yo_a;
                    zo = sel1 ? zo_b : zo_a;
                end
            end
            if (repulse && !sel1) start_a = (cyc == 5 || cyc == 48 || cyc == 49);
        end
        start_a = 1'b0;
    endtask

    vec_t        vt [6];
    int          dc, dn, be, dcnt;
    logic [31:0] xo, yo, zo, ex, ey, ez;
    real         p, xr, yr, zr;

    task automatic analytic_check(input string name, input logic [31:0] a, b, c,
                                  input logic [31:0] xa, ya);
        real ax, ay, az;
        ax = $itor($signed(a));
        ay = $itor($signed(b));
        az = $itor($signed(c)) / 1073741824.0;
        check_tol({name, "_xcos"}, xa, k16 * (ax * $cos(az) - ay * $sin(az)));
        check_tol({name, "_ysin"}, ya, k16 * (ay * $cos(az) + ax * $sin(az)));
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        x0_a = '0; y0_a = '0; z0_a = '0;
        x0_b = '0; y0_b = '0; z0_b = '0;

        p   = 1.0;
        k16 = 1.0;
        for (int i = 0; i < 31; i++) begin
            atan_ref[i] = $rtoi($atan(p) * 1073741824.0 + 0.5);
            if (i < 16) k16 = k16 * $sqrt(1.0 + p * p);
            p = p / 2.0;
        end

        #1;
        check32("rst_x",    xo_a, 32'h0);
        check32("rst_y",    yo_a, 32'h0);
        check32("rst_z",    zo_a, 32'h0);
        check32("rst_busy", 32'(busy_a), 32'h0);
        check32("rst_done", 32'(done_a), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vt[0].name = "pos_pi4";  vt[0].x0 = 32'h26DD3B6A; vt[0].y0 = 32'h0;        vt[0].z0 = 32'h3243F6A8;
        vt[1].name = "neg_pi4";  vt[1].x0 = 32'h26DD3B6A; vt[1].y0 = 32'h0;        vt[1].z0 = 32'hCDBC0958;
        vt[2].name = "max_wrap"; vt[2].x0 = 32'h7FFFFFFF; vt[2].y0 = 32'h7FFFFFFF; vt[2].z0 = 32'h0;
        vt[3].name = "z_outrng"; vt[3].x0 = 32'h20000000; vt[3].y0 = 32'hF0000000; vt[3].z0 = 32'h7FFFFFFF;
        vt[4].name = "neg_xy";   vt[4].x0 = 32'hC0000000; vt[4].y0 = 32'hE0000000; vt[4].z0 = 32'hF0000000;
        vt[5].name = "zero";     vt[5].x0 = 32'h0;        vt[5].y0 = 32'h0;        vt[5].z0 = 32'h0;
        for (int k = 0; k < 6; k++)
            model(vt[k].x0, vt[k].y0, vt[k].z0, 16, vt[k].ex, vt[k].ey, vt[k].ez);

        for (int k = 0; k < 6; k++) begin
            run_job(1'b0, vt[k].x0, vt[k].y0, vt[k].z0, 1'b0, dc, dn, be, xo, yo, zo);
            check32({vt[k].name, "_x"},    xo, vt[k].ex);
            check32({vt[k].name, "_y"},    yo, vt[k].ey);
            check32({vt[k].name, "_z"},    zo, vt[k].ez);
            check32({vt[k].name, "_lat"},  32'(dc), 32'd49);
            check32({vt[k].name, "_busy"}, 32'(be), 32'd0);
            if (k < 2) analytic_check(vt[k].name, vt[k].x0, vt[k].y0, vt[k].z0, xo, yo);
        end
        check_tol("pos_pi4_zres", vt[0].ez, 0.0);
        repeat (3) @(negedge clk);
        check32("hold_x", xo_a, vt[5].ex);
        check32("hold_z", zo_a, vt[5].ez);

        // start re-pulsed mid-job, on the last ZUPD and in the DONE cycle
        run_job(1'b0, vt[0].x0, vt[0].y0, vt[0].z0, 1'b1, dc, dn, be, xo, yo, zo);
        check32("repulse_lat",   32'(dc), 32'd49);
        check32("repulse_ndone", 32'(dn), 32'd1);
        check32("repulse_busy",  32'(be), 32'd0);
        check32("repulse_x",     xo, vt[0].ex);
        check32("repulse_y",     yo, vt[0].ey);

        // asynchronous reset in cycle 20 of a job
        @(negedge clk);
        x0_a = vt[1].x0; y0_a = vt[1].y0; z0_a = vt[1].z0; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        check32("pre_arst_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check32("arst_x",    xo_a, 32'h0);
        check32("arst_y",    yo_a, 32'h0);
        check32("arst_z",    zo_a, 32'h0);
        check32("arst_busy", 32'(busy_a), 32'h0);
        dcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_a === 1'b1) dcnt++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) dcnt++;
        end
        check32("arst_no_done", 32'(dcnt), 32'd0);
        run_job(1'b0, vt[0].x0, vt[0].y0, vt[0].z0, 1'b0, dc, dn, be, xo, yo, zo);
        check32("post_arst_lat", 32'(dc), 32'd49);
        check32("post_arst_x",   xo, vt[0].ex);
        check32("post_arst_y",   yo, vt[0].ey);
        check32("post_arst_z",   zo, vt[0].ez);

        // ITER=1: single positive rotation, z0 - atan(1)
        ez = 32'h10000000 - 32'(atan_ref[0]);
        run_job(1'b1, 32'h40000000, 32'h0, 32'h10000000, 1'b0, dc, dn, be, xo, yo, zo);
        check32("it1_lat",  32'(dc), 32'd4);
        check32("it1_busy", 32'(be), 32'd0);
        check32("it1_x",    xo, 32'h40000000);
        check32("it1_y",    yo, 32'h40000000);
        check32("it1_z",    zo, ez);

        for (int r = 0; r < 16; r++) begin
            logic [31:0] ra, rb, rc;
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            model(ra, rb, rc, 16, ex, ey, ez);
            run_job(1'b0, ra, rb, rc, 1'b0, dc, dn, be, xo, yo, zo);
            check32($sformatf("rnd%0d_x", r), xo, ex);
            check32($sformatf("rnd%0d_y", r), yo, ey);
            check32($sformatf("rnd%0d_z", r), zo, ez);
            check32($sformatf("rnd%0d_lat", r), 32'(dc), 32'd49);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
